// File: rtl/virtual_ds2431_mem_read_scratchpad.sv
// ---------------------------------------------------------------------------
// virtual_ds2431_mem_read_scratchpad
//
// Handler for the DS2431 Read Scratchpad command (0xAA). Once the command
// decoder raises cmdRunTrig, this block streams the following bytes through
// the shared byte transceiver, one byte at a time:
//   TA1, TA2, E/S, Scratchpad[TA1[2:0]..7], ~CRC16[7:0], ~CRC16[15:8]
//
// Ports
//   clk, nRst      : system clock, asynchronous active-low reset
//   cmdRunTrig     : level; a rising edge (re)starts the command
//   endCmd         : level; a rising edge aborts a running command
//   TA1, TA2, ES   : target address and ending offset
//   AA, PF         : authorization-accepted and partial flags
//   Scratchpad     : 8 bytes; byte i = Scratchpad[8i+7:8i]
//   ByteTransDone  : transceiver level; a rising edge ends the current byte
//   sentDat        : byte presented to the transceiver
//   nRxTx          : 1 = transmit, 0 = receive/idle
//   transTrig      : one-cycle start pulse per byte
//   cmdDone        : high when idle/completed normally
//   cmdFailed      : high after an aborted command
// ---------------------------------------------------------------------------
module virtual_ds2431_mem_read_scratchpad (
    input  logic        clk,
    input  logic        nRst,
    input  logic        cmdRunTrig,
    input  logic        endCmd,
    input  logic [7:0]  TA1,
    input  logic [7:0]  TA2,
    input  logic [2:0]  ES,
    input  logic        AA,
    input  logic        PF,
    input  logic [63:0] Scratchpad,
    input  logic        ByteTransDone,
    output logic [7:0]  sentDat,
    output logic        nRxTx,
    output logic        transTrig,
    output logic        cmdDone,
    output logic        cmdFailed
);

    typedef enum logic [2:0] {
        IDLE,
        SEND_TA1,
        SEND_TA2,
        SEND_ES,
        SEND_DATA,
        SEND_CRCL,
        SEND_CRCH
    } state_t;

    // CRC-16, reflected polynomial 0xA001, one byte per call.
    function automatic logic [15:0] crc_fold(input logic [15:0] c, input logic [7:0] d);
        logic [15:0] r;
        r = c ^ {8'h00, d};
        for (int i = 0; i < 8; i++) begin
            r = r[0] ? ((r >> 1) ^ 16'hA001) : (r >> 1);
        end
        return r;
    endfunction

    state_t      r_state, w_state;
    logic [7:0]  r_sentDat, w_sentDat;
    logic        r_nRxTx, w_nRxTx;
    logic        r_ioTrig, w_ioTrig;
    logic        r_ioPrev;
    logic        r_cmdDone, w_cmdDone;
    logic        r_cmdFailed, w_cmdFailed;
    logic [15:0] r_crc, w_crc;
    logic [2:0]  r_ptr, w_ptr;
    logic        r_runPrev, r_donePrev, r_endPrev;

    logic        w_runEdge, w_doneEdge, w_endEdge;
    logic [7:0]  w_esByte, w_curData, w_nxtData;
    logic [2:0]  w_ptrInc;

    assign w_runEdge  = cmdRunTrig    & ~r_runPrev;
    assign w_doneEdge = ByteTransDone & ~r_donePrev;
    assign w_endEdge  = endCmd        & ~r_endPrev;

    assign w_esByte  = {AA, 1'b0, PF, 2'b00, ES};
    assign w_ptrInc  = r_ptr + 3'd1;
    assign w_curData = Scratchpad[{r_ptr, 3'b000} +: 8];
    assign w_nxtData = Scratchpad[{w_ptrInc, 3'b000} +: 8];

    // ioTrig is held low in the cycle a byte is loaded and raised in the
    // next one, so each byte gives exactly one rising edge on transTrig.
    assign transTrig = r_ioTrig & ~r_ioPrev;
    assign sentDat   = r_sentDat;
    assign nRxTx     = r_nRxTx;
    assign cmdDone   = r_cmdDone;
    assign cmdFailed = r_cmdFailed;

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            r_state     <= IDLE;
            r_sentDat   <= 8'hFF;
            r_nRxTx     <= 1'b0;
            r_ioTrig    <= 1'b0;
            r_ioPrev    <= 1'b0;
            r_cmdDone   <= 1'b1;
            r_cmdFailed <= 1'b0;
            r_crc       <= 16'h0000;
            r_ptr       <= 3'd0;
            r_runPrev   <= 1'b0;
            r_donePrev  <= 1'b0;
            r_endPrev   <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_sentDat   <= w_sentDat;
            r_nRxTx     <= w_nRxTx;
            r_ioTrig    <= w_ioTrig;
            r_ioPrev    <= r_ioTrig;
            r_cmdDone   <= w_cmdDone;
            r_cmdFailed <= w_cmdFailed;
            r_crc       <= w_crc;
            r_ptr       <= w_ptr;
            r_runPrev   <= cmdRunTrig;
            r_donePrev  <= ByteTransDone;
            r_endPrev   <= endCmd;
        end
    end

    always_comb begin
        w_state     = r_state;
        w_sentDat   = r_sentDat;
        w_nRxTx     = r_nRxTx;
        w_ioTrig    = r_ioTrig;
        w_cmdDone   = r_cmdDone;
        w_cmdFailed = r_cmdFailed;
        w_crc       = r_crc;
        w_ptr       = r_ptr;

        if (w_runEdge) begin
            // Start (or restart) wins over a simultaneous abort.
            w_state     = SEND_TA1;
            w_sentDat   = TA1;
            w_nRxTx     = 1'b1;
            w_ioTrig    = 1'b0;
            w_cmdDone   = 1'b0;
            w_cmdFailed = 1'b0;
            w_crc       = crc_fold(crc_fold(16'h0000, 8'hAA), TA1);
            w_ptr       = TA1[2:0];
        end else if (w_endEdge && (r_state != IDLE)) begin
            w_state     = IDLE;
            w_sentDat   = 8'hFF;
            w_nRxTx     = 1'b0;
            w_ioTrig    = 1'b0;
            w_cmdDone   = 1'b0;
            w_cmdFailed = 1'b1;
        end else if (r_state != IDLE) begin
            if (w_doneEdge) begin
                w_ioTrig = 1'b0;
                case (r_state)
                    SEND_TA1: begin
                        w_state   = SEND_TA2;
                        w_sentDat = TA2;
                        w_crc     = crc_fold(r_crc, TA2);
                    end
                    SEND_TA2: begin
                        w_state   = SEND_ES;
                        w_sentDat = w_esByte;
                        w_crc     = crc_fold(r_crc, w_esByte);
                    end
                    SEND_ES: begin
                        w_state   = SEND_DATA;
                        w_sentDat = w_curData;
                        w_crc     = crc_fold(r_crc, w_curData);
                    end
                    SEND_DATA: begin
                        // r_ptr indexes the byte now on the wire.
                        if (r_ptr != 3'd7) begin
                            w_ptr     = w_ptrInc;
                            w_sentDat = w_nxtData;
                            w_crc     = crc_fold(r_crc, w_nxtData);
                        end else begin
                            w_state   = SEND_CRCL;
                            w_sentDat = ~r_crc[7:0];
                        end
                    end
                    SEND_CRCL: begin
                        w_state   = SEND_CRCH;
                        w_sentDat = ~r_crc[15:8];
                    end
                    SEND_CRCH: begin
                        w_state     = IDLE;
                        w_sentDat   = 8'hFF;
                        w_nRxTx     = 1'b0;
                        w_cmdDone   = 1'b1;
                        w_cmdFailed = 1'b0;
                    end
                    default: begin
                        w_state = IDLE;
                    end
                endcase
            end else if (!r_ioTrig) begin
                w_ioTrig = 1'b1;
            end
        end
    end

endmodule
